write_back_stage: RTL
=====================

// Module: write_back_stage
// PURPOSE
//  Registered, parametrised write-back stage of the pipelined MIPS core. Selects the
//  result from ALU, memory (with sub-word load extraction/extension) or link PC.
//  Registers the result with destination and RegWrite for the register file and
//  forwarding unit. Adds stall/flush control, $0 write suppression and a valid qualifier.
// PARAMETERS
//  B  32  datapath width; must be >= 32 (sub-word lanes taken from bits [31:0])
//  D  5   register-file address width
// PORTS
//  clk            in   1    clock, rising edge
//  reset          in   1    asynchronous, active-high reset
//  stall          in   1    hold all output registers
//  flush          in   1    squash: next registered valid_out/reg_write_out = 0
//  valid_in       in   1    incoming instruction is valid
//  mem_data       in   B    word read from data memory
//  ALU_data       in   B    ALU result
//  pc_link        in   B    return address for JAL/JALR (PC+8)
//  WbSel          in   2    00 ALU, 01 MEM, 10 PC_LINK, 11 ALU
//  LoadSize       in   2    00 word, 01 half, 10 byte, 11 treated as word
//  LoadSigned     in   1    1 sign-extend, 0 zero-extend sub-word loads
//  byte_off       in   2    load address bits [1:0]
//  RegWrite       in   1    instruction writes the register file
//  write_reg      in   D    destination register number
//  data_out       out  B    registered write-back data
//  write_reg_out  out  D    registered destination
//  reg_write_out  out  1    registered register-file write enable
//  valid_out      out  1    registered valid
// BEHAVIOUR
//  - Reset (async, immediate): data_out=0, write_reg_out=0, reg_write_out=0, valid_out=0.
//  - Latency 1 cycle: inputs sampled on rising clk edge appear on outputs after it.
//  - Priority per edge: reset > flush > stall > load.
//    flush: valid_out=0, reg_write_out=0; data_out/write_reg_out keep their values.
//    stall (no flush): all outputs hold.
//    load: valid_out=valid_in.
//          reg_write_out = valid_in & RegWrite & (write_reg != 0).
//          data_out and write_reg_out take the new values.
//  - Sub-word extraction (little-endian lanes, applied only when WbSel=01):
//    byte: lane = mem_data[8*byte_off +: 8]; half: lane = mem_data[16*byte_off[1] +: 16];
//    byte_off[0] ignored for half; no alignment trap. Extended to B bits by LoadSigned.
//    word: mem_data passed unchanged, LoadSigned ignored.
//  - WbSel=00/11 -> ALU_data; 10 -> pc_link; LoadSize ignored for non-MEM selects.
//  - Write to $0: data_out still loads, reg_write_out forced 0.
//  - valid_in=0 with RegWrite=1: reg_write_out=0 (bubble never writes).
//  - Reset asserted mid-stall or mid-flush: outputs clear immediately and stay
//    clear while reset=1. First edge after release acts on the current inputs.
// CONFIGURATION
//  WB_RETIRE_COUNT_EN defined: adds output retired_count (32 bits).
//    Async reset to 0. +1 on each edge where the stage loads with valid_in=1
//    (not on stall/flush edges). Wraps 0xFFFFFFFF -> 0.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 reset=1 with random inputs -> all outputs 0; release, WbSel=00, ALU_data=0x1234,
//    write_reg=5, RegWrite=1, valid_in=1 -> next cycle data_out=0x1234, reg_write_out=1.
//  2 WbSel=01, mem_data=0x80FF7F01, byte loads:
//    byte_off=3 signed -> 0xFFFFFF80; byte_off=2 unsigned -> 0x000000FF.
//    Half loads, byte_off=2: signed -> 0xFFFF80FF; unsigned -> 0x000080FF.
//  3 WbSel=10, pc_link=0x00400008, write_reg=31 -> data_out=0x00400008, write_reg_out=31.
//  4 write_reg=0, RegWrite=1 -> reg_write_out=0, data_out updated.
//    valid_in=0, RegWrite=1 -> reg_write_out=0.
//  5 stall=1 for 3 cycles while inputs change -> outputs constant.
//    stall=1 with flush=1 -> valid_out=0, reg_write_out=0 next cycle.
//  6 WB_RETIRE_COUNT_EN: 4 valid loads, 1 stall edge, 1 flush edge -> retired_count=4.
//    Preload near 0xFFFFFFFF -> wraps to 0.

Source files
------------

// File: rtl/write_back_stage_if.sv
// Write-back stage bus: pipeline-side control/data in, register-file side out.
// Optional macro WB_RETIRE_COUNT_EN adds the retired_count output.
interface write_back_stage_if #(
    parameter int B = 32,
    parameter int D = 5
);
    logic         stall;
    logic         flush;
    logic         valid_in;
    logic [B-1:0] mem_data;
    logic [B-1:0] ALU_data;
    logic [B-1:0] pc_link;
    logic [1:0]   WbSel;
    logic [1:0]   LoadSize;
    logic         LoadSigned;
    logic [1:0]   byte_off;
    logic         RegWrite;
    logic [D-1:0] write_reg;
    logic [B-1:0] data_out;
    logic [D-1:0] write_reg_out;
    logic         reg_write_out;
    logic         valid_out;
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0]  retired_count;
`endif

    modport master (
        output stall, flush, valid_in, mem_data, ALU_data, pc_link, WbSel,
               LoadSize, LoadSigned, byte_off, RegWrite, write_reg,
        input  data_out, write_reg_out, reg_write_out, valid_out
`ifdef WB_RETIRE_COUNT_EN
        , input retired_count
`endif
    );

    modport slave (
        input  stall, flush, valid_in, mem_data, ALU_data, pc_link, WbSel,
               LoadSize, LoadSigned, byte_off, RegWrite, write_reg,
        output data_out, write_reg_out, reg_write_out, valid_out
`ifdef WB_RETIRE_COUNT_EN
        , output retired_count
`endif
    );
endinterface

// File: rtl/write_back_stage.sv
// Registered MIPS write-back stage: result select (ALU / load lane / link PC),
// sub-word load extraction with sign/zero extension, stall/flush control and
// $0 write suppression.
// Optional macro WB_RETIRE_COUNT_EN adds a 32-bit wrapping retired_count.
module write_back_stage #(
    parameter int B = 32,
    parameter int D = 5
) (
    input  logic           clk,
    input  logic           reset,
    write_back_stage_if.slave wb
);

    logic [7:0]   lane8;
    logic [15:0]  lane16;
    logic [B-1:0] load_val;
    logic [B-1:0] sel_val;
    logic         load_en;

    // Only a non-stalled, non-flushed edge moves new values into the stage.
    assign load_en = !wb.flush && !wb.stall;

    // Little-endian lane pick, extension, then result mux.
    always_comb begin
        case (wb.byte_off)
            2'd0:    lane8 = wb.mem_data[7:0];
            2'd1:    lane8 = wb.mem_data[15:8];
            2'd2:    lane8 = wb.mem_data[23:16];
            default: lane8 = wb.mem_data[31:24];
        endcase
        // Half loads ignore byte_off[0]; misalignment is not trapped here.
        lane16 = wb.byte_off[1] ? wb.mem_data[31:16] : wb.mem_data[15:0];

        case (wb.LoadSize)
            2'b01:   load_val = {{(B-16){wb.LoadSigned & lane16[15]}}, lane16};
            2'b10:   load_val = {{(B-8){wb.LoadSigned & lane8[7]}}, lane8};
            default: load_val = wb.mem_data;
        endcase

        case (wb.WbSel)
            2'b01:   sel_val = load_val;
            2'b10:   sel_val = wb.pc_link;
            default: sel_val = wb.ALU_data;
        endcase
    end

    // Output registers: reset > flush > stall > load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb.data_out      <= '0;
            wb.write_reg_out <= '0;
            wb.reg_write_out <= 1'b0;
            wb.valid_out     <= 1'b0;
        end else if (wb.flush) begin
            // Squash keeps the stale data/destination; only the qualifiers drop.
            wb.reg_write_out <= 1'b0;
            wb.valid_out     <= 1'b0;
        end else if (!wb.stall) begin
            wb.data_out      <= sel_val;
            wb.write_reg_out <= wb.write_reg;
            wb.reg_write_out <= wb.valid_in & wb.RegWrite & (wb.write_reg != '0);
            wb.valid_out     <= wb.valid_in;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    // Count instructions that actually retire through the stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wb.retired_count <= '0;
        else if (load_en && wb.valid_in)
            wb.retired_count <= wb.retired_count + 32'd1;
    end
`else
    logic unused_load_en;
    assign unused_load_en = load_en;
`endif

endmodule
